// File: rtl/conv_pkg.sv
// Shared state encoding and sizing helpers for the 2-D convolution sequencer.
package conv_pkg;

   localparam int unsigned DefBits       = 9;
   localparam int unsigned DefKernelSize = 3;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StKclr   = 3'd1,
      StKload  = 3'd2,
      StKwait  = 3'd3,
      StStream = 3'd4,
      StDrain  = 3'd5,
      StDone   = 3'd6
   } conv_state_e;

   function automatic int unsigned kw(input int unsigned k);
      return k * k;
   endfunction

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster row/column tracker for streamed pixels, with last-pixel and
// fully-populated-window flags for the pixel currently at the counter.
module conv_pos_counter
   import conv_pkg::*;
#(
   parameter int unsigned IMG_WIDTH   = 8,
   parameter int unsigned IMG_HEIGHT  = 8,
   parameter int unsigned KERNEL_SIZE = DefKernelSize
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_en,
   input  logic                         i_clr,
   output logic [cnt_w(IMG_HEIGHT)-1:0] o_row,
   output logic [cnt_w(IMG_WIDTH)-1:0]  o_col,
   output logic                         o_last,
   output logic                         o_win_valid
);

   localparam int unsigned RW = cnt_w(IMG_HEIGHT);
   localparam int unsigned CW = cnt_w(IMG_WIDTH);
   localparam logic [RW-1:0] RowMax = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] ColMax = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] RowWin = RW'(KERNEL_SIZE - 1);
   localparam logic [CW-1:0] ColWin = CW'(KERNEL_SIZE - 1);

   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          w_col_wrap;

   assign w_col_wrap = (r_col == ColMax);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_en) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= (r_row == RowMax) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row       = r_row;
   assign o_col       = r_col;
   assign o_last      = (r_row == RowMax) && w_col_wrap;
   assign o_win_valid = (r_row >= RowWin) && (r_col >= ColWin);

endmodule

// File: rtl/conv_controller.sv
// Frame sequencer for the convolution datapath: kernel load, pixel streaming,
// valid-window strobing and coordinate-tagged result tracking.
module conv_controller
   import conv_pkg::*;
#(
   parameter int unsigned BITS        = DefBits,
   parameter int unsigned KERNEL_SIZE = DefKernelSize,
   parameter int unsigned IMG_WIDTH   = 8,
   parameter int unsigned IMG_HEIGHT  = 8,
   parameter int unsigned MULT_LAT    = 1
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_start,
   input  logic                         i_reuse_kernel,
   input  logic                         i_abort,
   input  logic                         i_k_valid,
   input  logic [BITS-1:0]              i_k_data,
   output logic                         o_k_ready,
   output logic                         o_kmem_reset,
   output logic                         o_kmem_write_en,
   output logic [BITS-1:0]              o_kmem_data,
   input  logic                         i_kmem_ready,
   input  logic                         i_pix_valid,
   input  logic [BITS-1:0]              i_pix_data,
   output logic                         o_pix_ready,
   output logic                         o_sreg_write_en,
   output logic [BITS-1:0]              o_sreg_data,
   output logic                         o_mult_out_en,
   output logic                         o_result_valid,
   output logic [cnt_w(IMG_HEIGHT)-1:0] o_result_row,
   output logic [cnt_w(IMG_WIDTH)-1:0]  o_result_col,
   output logic                         o_busy,
   output logic                         o_done
);

   localparam int unsigned KW  = kw(KERNEL_SIZE);
   localparam int unsigned KCW = cnt_w(KW);
   localparam int unsigned DCW = cnt_w(MULT_LAT + 1);
   localparam int unsigned RW  = cnt_w(IMG_HEIGHT);
   localparam int unsigned CW  = cnt_w(IMG_WIDTH);
   localparam logic [KCW-1:0] KLast  = KCW'(KW - 1);
   localparam logic [DCW-1:0] DLast  = DCW'(MULT_LAT);
   localparam logic [RW-1:0]  RowOff = RW'(KERNEL_SIZE - 1);
   localparam logic [CW-1:0]  ColOff = CW'(KERNEL_SIZE - 1);

   conv_state_e    r_state, w_state_d;
   logic           r_k_ready, r_pix_ready, r_kmem_reset, r_busy, r_done;
   logic [KCW-1:0] r_kcount;
   logic [DCW-1:0] r_dcount;

   logic           w_k_acc, w_pix_acc, w_win_acc, w_last, w_win_valid, w_pos_clr;
   logic [RW-1:0]  w_row;
   logic [CW-1:0]  w_col;

   logic           r_mult_out_en;
   logic [RW-1:0]  r_mult_row;
   logic [CW-1:0]  r_mult_col;
   logic           r_vld_line [MULT_LAT];
   logic [RW-1:0]  r_row_line [MULT_LAT];
   logic [CW-1:0]  r_col_line [MULT_LAT];

   assign w_k_acc   = i_k_valid & r_k_ready;
   assign w_pix_acc = i_pix_valid & r_pix_ready;
   assign w_win_acc = w_pix_acc & w_win_valid;
   assign w_pos_clr = i_abort | (r_state == StDone);

   conv_pos_counter #(
      .IMG_WIDTH   (IMG_WIDTH),
      .IMG_HEIGHT  (IMG_HEIGHT),
      .KERNEL_SIZE (KERNEL_SIZE)
   ) u_pos (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_en        (w_pix_acc),
      .i_clr       (w_pos_clr),
      .o_row       (w_row),
      .o_col       (w_col),
      .o_last      (w_last),
      .o_win_valid (w_win_valid)
   );

   // Abort overrides everything, including a start seen in the same cycle.
   always_comb begin
      w_state_d = r_state;
      if (i_abort) begin
         w_state_d = StIdle;
      end else begin
         unique case (r_state)
            StIdle:   if (i_start) w_state_d = i_reuse_kernel ? StStream : StKclr;
            StKclr:   w_state_d = StKload;
            StKload:  if (w_k_acc && (r_kcount == KLast)) w_state_d = StKwait;
            StKwait:  if (i_kmem_ready) w_state_d = StStream;
            StStream: if (w_pix_acc && w_last) w_state_d = StDrain;
            StDrain:  if (r_dcount == DLast) w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_k_ready    <= 1'b0;
         r_pix_ready  <= 1'b0;
         r_kmem_reset <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_kcount     <= '0;
         r_dcount     <= '0;
      end else begin
         r_state      <= w_state_d;
         r_k_ready    <= (w_state_d == StKload);
         r_pix_ready  <= (w_state_d == StStream);
         r_kmem_reset <= (w_state_d == StKclr);
         r_busy       <= (w_state_d != StIdle);
         r_done       <= (w_state_d == StDone);
         if (w_state_d != StKload) r_kcount <= '0;
         else if (w_k_acc)         r_kcount <= r_kcount + 1'b1;
         r_dcount <= (r_state == StDrain) ? r_dcount + 1'b1 : '0;
      end
   end

   // Valid/coordinate delay line modelling the multiplier latency.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mult_out_en <= 1'b0;
         r_mult_row    <= '0;
         r_mult_col    <= '0;
         for (int i = 0; i < MULT_LAT; i++) begin
            r_vld_line[i] <= 1'b0;
            r_row_line[i] <= '0;
            r_col_line[i] <= '0;
         end
      end else if (i_abort) begin
         r_mult_out_en <= 1'b0;
         r_mult_row    <= '0;
         r_mult_col    <= '0;
         for (int i = 0; i < MULT_LAT; i++) begin
            r_vld_line[i] <= 1'b0;
            r_row_line[i] <= '0;
            r_col_line[i] <= '0;
         end
      end else begin
         r_mult_out_en <= w_win_acc;
         r_mult_row    <= w_win_acc ? w_row - RowOff : '0;
         r_mult_col    <= w_win_acc ? w_col - ColOff : '0;
         r_vld_line[0] <= r_mult_out_en;
         r_row_line[0] <= r_mult_row;
         r_col_line[0] <= r_mult_col;
         for (int i = 1; i < MULT_LAT; i++) begin
            r_vld_line[i] <= r_vld_line[i-1];
            r_row_line[i] <= r_row_line[i-1];
            r_col_line[i] <= r_col_line[i-1];
         end
      end
   end

   assign o_k_ready       = r_k_ready;
   assign o_kmem_reset    = r_kmem_reset;
   assign o_kmem_write_en = w_k_acc;
   assign o_kmem_data     = w_k_acc ? i_k_data : '0;
   assign o_pix_ready     = r_pix_ready;
   assign o_sreg_write_en = w_pix_acc;
   assign o_sreg_data     = w_pix_acc ? i_pix_data : '0;
   assign o_mult_out_en   = r_mult_out_en;
   assign o_result_valid  = r_vld_line[MULT_LAT-1];
   assign o_result_row    = r_row_line[MULT_LAT-1];
   assign o_result_col    = r_col_line[MULT_LAT-1];
   assign o_busy          = r_busy;
   assign o_done          = r_done;

endmodule

// File: tb/tb_conv_controller.sv
// Directed bench for conv_controller: scoreboard of expected result coordinates
// and arrival cycles, filled from an independent raster model of accepted pixels.
module tb_conv_controller;

   localparam int unsigned BITS = 9;
   localparam int unsigned K    = 3;
   localparam int unsigned W    = 8;
   localparam int unsigned H    = 8;
   localparam int unsigned ML   = 1;

   logic            clk = 1'b0;
   logic            reset_n, start, reuse_kernel, abort;
   logic            k_valid, kmem_ready, pix_valid;
   logic [BITS-1:0] k_data, pix_data;
   logic            k_ready, kmem_reset, kmem_write_en, pix_ready, sreg_write_en;
   logic [BITS-1:0] kmem_data, sreg_data;
   logic            mult_out_en, result_valid, busy, done;
   logic [2:0]      result_row, result_col;

   always #5 clk = ~clk;

   conv_controller #(
      .BITS        (BITS),
      .KERNEL_SIZE (K),
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H),
      .MULT_LAT    (ML)
   ) dut (
      .i_clk           (clk),
      .i_reset_n       (reset_n),
      .i_start         (start),
      .i_reuse_kernel  (reuse_kernel),
      .i_abort         (abort),
      .i_k_valid       (k_valid),
      .i_k_data        (k_data),
      .o_k_ready       (k_ready),
      .o_kmem_reset    (kmem_reset),
      .o_kmem_write_en (kmem_write_en),
      .o_kmem_data     (kmem_data),
      .i_kmem_ready    (kmem_ready),
      .i_pix_valid     (pix_valid),
      .i_pix_data      (pix_data),
      .o_pix_ready     (pix_ready),
      .o_sreg_write_en (sreg_write_en),
      .o_sreg_data     (sreg_data),
      .o_mult_out_en   (mult_out_en),
      .o_result_valid  (result_valid),
      .o_result_row    (result_row),
      .o_result_col    (result_col),
      .o_busy          (busy),
      .o_done          (done)
   );

   typedef struct {int row; int col; int cyc;} exp_t;
   exp_t sb[$];

   int n_checks = 0, n_pass = 0, cyc = 0;
   int n_sreg, n_mult, n_res, n_kwr = 0, n_kclr = 0, n_done = 0, k_exp = 0;
   int strobe_err, mult_err, m_row, m_col, first_rc, last_rc;
   logic prev_win;
   logic s_pacc, s_kacc, s_k_ready, s_pix_ready, s_kmem_reset, s_busy, s_done;
   logic s_mult, s_result_valid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mon_reset();
      sb.delete();
      m_row = 0; m_col = 0; prev_win = 1'b0;
      n_sreg = 0; n_mult = 0; n_res = 0; strobe_err = 0; mult_err = 0;
      first_rc = -1; last_rc = -1;
   endtask

   // Negedge observation: snapshot, strobe tallies, scoreboard pop and push.
   task automatic sample();
      exp_t e;
      logic pacc, kacc, win;
      pacc = pix_valid && pix_ready;
      kacc = k_valid && k_ready;
      s_pacc = pacc; s_kacc = kacc; s_k_ready = k_ready; s_pix_ready = pix_ready;
      s_kmem_reset = kmem_reset; s_busy = busy; s_done = done;
      s_mult = mult_out_en; s_result_valid = result_valid;
      if (sreg_write_en !== pacc || (pacc && sreg_data !== pix_data)) strobe_err++;
      if (kmem_write_en !== kacc) strobe_err++;
      if (mult_out_en !== prev_win) mult_err++;
      n_sreg += int'(sreg_write_en);
      n_mult += int'(mult_out_en);
      n_kclr += int'(kmem_reset);
      n_done += int'(done);
      if (kmem_write_en) begin
         check("kmem_data", kmem_data, k_exp + 1);
         k_exp++;
         n_kwr++;
      end
      if (result_valid) begin
         if (sb.size() == 0) begin
            check("result_unexpected", result_valid, 0);
         end else begin
            e = sb.pop_front();
            check("result_coord", {result_row, result_col}, e.row * 8 + e.col);
            check("result_cycle", cyc, e.cyc);
            if (n_res == 0) first_rc = result_row * 8 + result_col;
            last_rc = result_row * 8 + result_col;
            n_res++;
         end
      end
      win = pacc && (m_row >= K - 1) && (m_col >= K - 1);
      if (win) sb.push_back('{m_row - (K - 1), m_col - (K - 1), cyc + 1 + ML});
      if (pacc) begin
         if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
      prev_win = win;
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic begin_frame(input logic reuse);
      mon_reset();
      start = 1'b1;
      reuse_kernel = reuse;
      step();
      start = 1'b0;
   endtask

   task automatic drive_frame(input int n, input int gap_pct, input int start_at,
                              input string tag);
      int p = 0, g = 0;
      while (p < n && g < 3000) begin
         pix_valid = ($urandom_range(99) >= gap_pct);
         pix_data  = BITS'(p * 37 + 5);
         start     = (p == start_at);
         step();
         if (s_pacc) p++;
         g++;
      end
      pix_valid = 1'b0;
      start = 1'b0;
      check({tag, "_pixels"}, p, n);
   endtask

   task automatic wait_done(input string tag);
      int g = 0;
      logic seen = 1'b0;
      while (!seen && g < 40) begin
         step();
         if (s_done) seen = 1'b1;
         g++;
      end
      check({tag, "_done_seen"}, seen, 1);
      step();
      check({tag, "_idle_after_done"}, {s_busy, s_done}, 0);
   endtask

   task automatic frame_checks(input string tag);
      check({tag, "_sreg_count"}, n_sreg, W * H);
      check({tag, "_mult_count"}, n_mult, (W - K + 1) * (H - K + 1));
      check({tag, "_result_count"}, n_res, (W - K + 1) * (H - K + 1));
      check({tag, "_strobe_errors"}, strobe_err, 0);
      check({tag, "_mult_timing_errors"}, mult_err, 0);
      check({tag, "_first_result"}, first_rc, 0);
      check({tag, "_last_result"}, last_rc, (H - K) * 8 + (W - K));
      check({tag, "_scoreboard_empty"}, sb.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, g, wait_err, res_at_abort, done_at_abort;
      reset_n = 1'b0; start = 1'b0; reuse_kernel = 1'b0; abort = 1'b0;
      k_valid = 1'b0; k_data = '0; kmem_ready = 1'b0; pix_valid = 1'b0; pix_data = '0;
      mon_reset();
      step();
      step();
      check("reset_outputs", {k_ready, kmem_reset, kmem_write_en, kmem_data, pix_ready,
            sreg_write_en, sreg_data, mult_out_en, result_valid, result_row, result_col,
            busy, done}, 0);
      reset_n = 1'b1;
      step();

      // Kernel load followed by a continuous full frame.
      begin_frame(1'b0);
      step();
      check("kclr_state", {s_kmem_reset, s_k_ready, s_busy}, 3'b101);
      idx = 0; g = 0;
      while (idx < 9 && g < 200) begin
         k_valid = ($urandom_range(3) != 0);
         k_data  = BITS'(idx + 1);
         step();
         if (s_kacc) idx++;
         g++;
      end
      check("kernel_words_accepted", idx, 9);
      k_valid = 1'b1;
      k_data  = BITS'(99);
      wait_err = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (s_k_ready || s_pix_ready || !s_busy) wait_err++;
      end
      check("kwait_hold", wait_err, 0);
      kmem_ready = 1'b1;
      step();
      kmem_ready = 1'b0;
      k_valid = 1'b0;
      step();
      check("kwait_release", {s_pix_ready, s_k_ready}, 2'b10);
      check("kmem_write_count", n_kwr, 9);
      check("kclr_count", n_kclr, 1);
      drive_frame(W * H, 0, -1, "full");
      wait_done("full");
      frame_checks("full");
      check("full_done_count", n_done, 1);

      // Reused kernel, random stalls, and a start pulse while busy.
      begin_frame(1'b1);
      reuse_kernel = 1'b0;
      step();
      check("reuse_stream_entry", {s_pix_ready, s_busy, s_kmem_reset}, 3'b110);
      drive_frame(W * H, 40, 20, "stall");
      wait_done("stall");
      frame_checks("stall");
      check("stall_no_kernel_activity", {8'(n_kclr), 8'(n_kwr)}, {8'd1, 8'd9});
      check("stall_done_count", n_done, 2);

      // Abort after pixel index 30 has been accepted.
      begin_frame(1'b1);
      drive_frame(31, 0, -1, "abort");
      abort = 1'b1;
      step();
      abort = 1'b0;
      sb.delete();
      res_at_abort = n_res;
      done_at_abort = n_done;
      step();
      check("abort_idle", {s_busy, s_pix_ready, s_mult, s_result_valid}, 0);
      for (int i = 0; i < 6; i++) step();
      check("abort_no_result", n_res, res_at_abort);
      check("abort_no_done", n_done, done_at_abort);

      begin_frame(1'b1);
      drive_frame(W * H, 0, -1, "post_abort");
      wait_done("post_abort");
      frame_checks("post_abort");

      // Asynchronous reset in the middle of streaming.
      begin_frame(1'b1);
      drive_frame(20, 0, -1, "rst");
      pix_valid = 1'b1;
      k_valid = 1'b1;
      #2;
      reset_n = 1'b0;
      mon_reset();
      #1;
      check("async_reset_outputs", {k_ready, kmem_reset, kmem_write_en, kmem_data,
            pix_ready, sreg_write_en, sreg_data, mult_out_en, result_valid, result_row,
            result_col, busy, done}, 0);
      pix_valid = 1'b0;
      k_valid = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      check("post_reset_idle", {s_busy, s_pix_ready, s_done}, 0);
      check("post_reset_done_count", n_done, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
